gpio_seq: RTL and testbench
===========================

GPIO_SEQ -- requirements
Module: gpio_seq

Interface
REQ-001 SHALL have parameter DW, default 8: GPIO bank width, matching the GPIO register block it drives.
REQ-002 SHALL have parameter DEPTH, default 16: pattern table entries (power of 2); AW = clog2(DEPTH).
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port tbl_wen, input, 1: table write strobe.
REQ-006 Port tbl_addr, input, AW: table write index.
REQ-007 Port tbl_wdata, input, 2*DW+16: {oe[DW-1:0], out[DW-1:0], dur[15:0]}.
REQ-008 Port cfg_len, input, AW: index of the last step in the pattern.
REQ-009 Port cfg_loops, input, 16: pattern repetitions; 0 = run until stopped.
REQ-010 Port ctl_start, input, 1: single-cycle start pulse.
REQ-011 Port ctl_stop, input, 1: single-cycle stop pulse.
REQ-012 Port trg_i, input, 1: external asynchronous start trigger (see Configuration).
REQ-013 Port gpio_e, output, DW: output enable to the GPIO pins.
REQ-014 Port gpio_o, output, DW: output data to the GPIO pins.
REQ-015 Port sts_busy, output, 1: high while in state RUN.
REQ-016 Port sts_step, output, AW: current step index.
REQ-017 Port irq, output, 1: one-cycle pulse on natural completion.

Function
REQ-018 SHALL hold the table in DEPTH registers; a write on tbl_wen takes effect on the next edge and is permitted in any state.
REQ-019 SHALL implement the FSM states IDLE and RUN; IDLE drives gpio_e = 0, gpio_o = 0, and step = 0.
REQ-020 IDLE -> RUN on the edge sampling ctl_start=1; on that same edge, gpio_e/gpio_o <= table[0].oe/out, step <= 0, duration counter <= table[0].dur, loop counter <= 0.
REQ-021 Each step SHALL hold its outputs for dur+1 cycles (dur=0 gives 1 cycle; dur=0xFFFF gives 65536 cycles).
REQ-022 At step end with step < cfg_len: step <= step+1, and outputs and counter SHALL load from table[step+1], with no gap cycle.
REQ-023 At step end with step == cfg_len: loop counter +1; if cfg_loops != 0 and the new count == cfg_loops, SHALL go -> IDLE and assert irq for 1 cycle; otherwise step SHALL wrap to 0 and load table[0].
REQ-024 cfg_len = 0 SHALL repeat step 0 only; with cfg_loops = 0 the sequencer SHALL run indefinitely.
REQ-025 ctl_stop in RUN SHALL cause -> IDLE on the next edge with outputs cleared and no irq; ctl_stop in IDLE SHALL be ignored.
REQ-026 ctl_start and ctl_stop in the same cycle: stop SHALL win, and the FSM SHALL end or remain in IDLE.
REQ-027 ctl_start in RUN SHALL be ignored, with no restart.
REQ-028 A table entry rewritten during RUN SHALL take effect the next time that entry is loaded; the active step SHALL be unaffected.
REQ-029 cfg_len and cfg_loops SHALL be sampled continuously; software SHALL change them only in IDLE, and behaviour under change in RUN is undefined but SHALL not lock up the FSM.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 Asserting rst SHALL asynchronously force: state IDLE, gpio_e = 0, gpio_o = 0, sts_busy = 0, sts_step = 0, irq = 0, counters = 0, all table entries = 0.
REQ-032 Reset mid-RUN SHALL abort immediately with no irq; operation SHALL resume only on a new start after deassertion.

Configuration
REQ-033 Macro GPIO_SEQ_TRIG_EN defined: trg_i SHALL pass through a 2-FF synchronizer plus rising-edge detect; a detected edge SHALL act exactly as ctl_start, so outputs show step 0 three edges after trg_i rises, and ctl_stop precedence SHALL still apply.
REQ-034 Macro GPIO_SEQ_TRIG_EN undefined: trg_i port SHALL exist but be ignored, and no synchronizer flops SHALL be present.

Verification
REQ-035 Table[0]={oe=FF,out=55,dur=2}, [1]={FF,AA,0}, cfg_len=1, cfg_loops=2, start -> gpio_o 55x3, AAx1, 55x3, AAx1, then 00; irq single pulse on the IDLE entry edge; busy 8 cycles.
REQ-036 Same table, cfg_loops=0, ctl_stop after 20 cycles -> pattern repeats until stop, outputs 00 next cycle, irq never asserted.
REQ-037 ctl_start and ctl_stop in the same cycle from IDLE -> stays IDLE; in RUN, the start alone -> no restart, sts_step continues.
REQ-038 Rewrite table[1].out=0F during step 0 of the first loop -> the first loop shows 0F at step 1.
REQ-039 Assert rst during step 1 of a dur=100 step -> outputs 0 immediately (asynchronous), irq 0, table read back as zero-driven pattern on next start.
REQ-040 With GPIO_SEQ_TRIG_EN, trg_i 0->1 -> step 0 outputs after 3 edges; held high -> no retrigger; without the macro -> no response.

Source files
------------

// File: rtl/gpio_seq.sv
// GPIO pattern sequencer: steps through a register table of {oe, out, dur} entries.
// Optional macro GPIO_SEQ_TRIG_EN enables a synchronised rising-edge start on trg_i.
module gpio_seq #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned EW   = 2 * DW + 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tbl_wen,
  input  logic [AW-1:0] tbl_addr,
  input  logic [EW-1:0] tbl_wdata,
  input  logic [AW-1:0] cfg_len,
  input  logic [15:0]   cfg_loops,
  input  logic          ctl_start,
  input  logic          ctl_stop,
  input  logic          trg_i,
  output logic [DW-1:0] gpio_e,
  output logic [DW-1:0] gpio_o,
  output logic          sts_busy,
  output logic [AW-1:0] sts_step,
  output logic          irq
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [EW-1:0] tbl_q [DEPTH];

  logic [DW-1:0] gpio_e_q, gpio_e_d;
  logic [DW-1:0] gpio_o_q, gpio_o_d;
  logic [AW-1:0] step_q, step_d;
  logic [15:0]   dur_q, dur_d;
  logic [15:0]   loop_q, loop_d;
  logic          irq_q, irq_d;

  logic          start_req;
  logic          go_run;
  logic          step_end;
  logic          pat_end;
  logic          last_loop;
  logic [15:0]   loop_inc;
  logic [AW-1:0] step_inc;
  logic [EW-1:0] ent_first;
  logic [EW-1:0] ent_next;

  // Pattern table; writes are accepted in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_q[i] <= '0;
      end
    end else if (tbl_wen) begin
      tbl_q[tbl_addr] <= tbl_wdata;
    end
  end

`ifdef GPIO_SEQ_TRIG_EN
  // [0],[1]: two-flop synchroniser, [2]: previous synchronised level for edge detect.
  logic [2:0] trg_q;
  logic       trg_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trg_q <= '0;
    end else begin
      trg_q <= {trg_q[1:0], trg_i};
    end
  end

  assign trg_edge  = trg_q[1] & ~trg_q[2];
  assign start_req = ctl_start | trg_edge;
`else
  logic unused_trg;
  assign unused_trg = trg_i;
  assign start_req  = ctl_start;
`endif

  assign go_run    = start_req & ~ctl_stop;
  assign step_end  = (dur_q == 16'd0);
  // >= rather than == so a cfg_len lowered mid-run still ends the pattern.
  assign pat_end   = (step_q >= cfg_len);
  assign loop_inc  = loop_q + 16'd1;
  assign last_loop = (cfg_loops != 16'd0) && (loop_inc >= cfg_loops);
  assign step_inc  = step_q + AW'(1);
  assign ent_first = tbl_q[0];
  assign ent_next  = tbl_q[step_inc];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (go_run) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (ctl_stop) begin
          state_d = StIdle;
        end else if (step_end && pat_end && last_loop) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    gpio_e_d = gpio_e_q;
    gpio_o_d = gpio_o_q;
    step_d   = step_q;
    dur_d    = dur_q;
    loop_d   = loop_q;
    irq_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        gpio_e_d = '0;
        gpio_o_d = '0;
        step_d   = '0;
        dur_d    = '0;
        loop_d   = '0;
        if (go_run) begin
          gpio_e_d = ent_first[EW-1 -: DW];
          gpio_o_d = ent_first[DW+15 -: DW];
          dur_d    = ent_first[15:0];
        end
      end
      StRun: begin
        if (ctl_stop) begin
          gpio_e_d = '0;
          gpio_o_d = '0;
          step_d   = '0;
          dur_d    = '0;
          loop_d   = '0;
        end else if (!step_end) begin
          dur_d = dur_q - 16'd1;
        end else if (!pat_end) begin
          step_d   = step_inc;
          gpio_e_d = ent_next[EW-1 -: DW];
          gpio_o_d = ent_next[DW+15 -: DW];
          dur_d    = ent_next[15:0];
        end else if (last_loop) begin
          gpio_e_d = '0;
          gpio_o_d = '0;
          step_d   = '0;
          dur_d    = '0;
          loop_d   = '0;
          irq_d    = 1'b1;
        end else begin
          loop_d   = loop_inc;
          step_d   = '0;
          gpio_e_d = ent_first[EW-1 -: DW];
          gpio_o_d = ent_first[DW+15 -: DW];
          dur_d    = ent_first[15:0];
        end
      end
      default: begin
        gpio_e_d = '0;
        gpio_o_d = '0;
        step_d   = '0;
        dur_d    = '0;
        loop_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_e_q <= '0;
      gpio_o_q <= '0;
      step_q   <= '0;
      dur_q    <= '0;
      loop_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      gpio_e_q <= gpio_e_d;
      gpio_o_q <= gpio_o_d;
      step_q   <= step_d;
      dur_q    <= dur_d;
      loop_q   <= loop_d;
      irq_q    <= irq_d;
    end
  end

  assign gpio_e   = gpio_e_q;
  assign gpio_o   = gpio_o_q;
  assign sts_step = step_q;
  assign sts_busy = (state_q == StRun);
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_seq.sv
// Directed self-checking bench for gpio_seq; inputs change and outputs are sampled on negedge.
// Trigger behaviour is checked for whichever GPIO_SEQ_TRIG_EN build is compiled.
module tb_gpio_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tbl_wen = 1'b0;
  logic [3:0]  tbl_addr = '0;
  logic [31:0] tbl_wdata = '0;
  logic [3:0]  cfg_len = '0;
  logic [15:0] cfg_loops = '0;
  logic        ctl_start = 1'b0;
  logic        ctl_stop = 1'b0;
  logic        trg_i = 1'b0;
  logic [7:0]  gpio_e;
  logic [7:0]  gpio_o;
  logic        sts_busy;
  logic [3:0]  sts_step;
  logic        irq;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [7:0] exp_pat [8] = '{8'h55, 8'h55, 8'h55, 8'hAA, 8'h55, 8'h55, 8'h55, 8'hAA};

  gpio_seq #(
    .DW    (8),
    .DEPTH (16)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .tbl_wen   (tbl_wen),
    .tbl_addr  (tbl_addr),
    .tbl_wdata (tbl_wdata),
    .cfg_len   (cfg_len),
    .cfg_loops (cfg_loops),
    .ctl_start (ctl_start),
    .ctl_stop  (ctl_stop),
    .trg_i     (trg_i),
    .gpio_e    (gpio_e),
    .gpio_o    (gpio_o),
    .sts_busy  (sts_busy),
    .sts_step  (sts_step),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] oe, input logic [7:0] out,
                    input logic [15:0] dur);
    tbl_wen   = 1'b1;
    tbl_addr  = addr;
    tbl_wdata = {oe, out, dur};
    tick();
    tbl_wen   = 1'b0;
  endtask

  task automatic start_pulse();
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
  endtask

  task automatic stop_pulse();
    ctl_stop = 1'b1;
    tick();
    ctl_stop = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    check_eq("rst_gpio_e", 32'(gpio_e), 'h0);
    check_eq("rst_gpio_o", 32'(gpio_o), 'h0);
    check_eq("rst_busy", 32'(sts_busy), 0);
    check_eq("rst_step", 32'(sts_step), 0);
    check_eq("rst_irq", 32'(irq), 0);
    tick();
    rst = 1'b0;
    tick();

    // Two loops of a two-step pattern
    wr(4'd0, 8'hFF, 8'h55, 16'd2);
    wr(4'd1, 8'hFF, 8'hAA, 16'd0);
    cfg_len   = 4'd1;
    cfg_loops = 16'd2;
    start_pulse();
    check_eq("t1_gpio_e", 32'(gpio_e), 'hFF);
    for (int i = 0; i < 8; i++) begin
      check_eq("t1_out", 32'(gpio_o), 32'(exp_pat[i]));
      check_eq("t1_step", 32'(sts_step), (i % 4 == 3) ? 1 : 0);
      check_eq("t1_busy", 32'(sts_busy), 1);
      check_eq("t1_irq_low", 32'(irq), 0);
      tick();
    end
    check_eq("t1_irq", 32'(irq), 1);
    check_eq("t1_out_idle", 32'(gpio_o), 'h0);
    check_eq("t1_oe_idle", 32'(gpio_e), 'h0);
    check_eq("t1_busy_idle", 32'(sts_busy), 0);
    tick();
    check_eq("t1_irq_1cyc", 32'(irq), 0);

    // cfg_len = 0 repeats step 0 only
    cfg_len   = 4'd0;
    cfg_loops = 16'd3;
    start_pulse();
    for (int i = 0; i < 9; i++) begin
      check_eq("len0_out", 32'(gpio_o), 'h55);
      check_eq("len0_step", 32'(sts_step), 0);
      check_eq("len0_busy", 32'(sts_busy), 1);
      tick();
    end
    check_eq("len0_irq", 32'(irq), 1);
    check_eq("len0_busy_end", 32'(sts_busy), 0);
    tick();

    // Endless run, then stop
    cfg_len   = 4'd1;
    cfg_loops = 16'd0;
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      check_eq("t2_out", 32'(gpio_o), (i % 4 == 3) ? 'hAA : 'h55);
      check_eq("t2_irq", 32'(irq), 0);
      tick();
    end
    stop_pulse();
    check_eq("t2_out_stop", 32'(gpio_o), 'h0);
    check_eq("t2_oe_stop", 32'(gpio_e), 'h0);
    check_eq("t2_busy_stop", 32'(sts_busy), 0);
    check_eq("t2_irq_stop", 32'(irq), 0);
    tick();
    check_eq("t2_irq_after", 32'(irq), 0);

    // Start and stop together from IDLE
    ctl_start = 1'b1;
    ctl_stop  = 1'b1;
    tick();
    ctl_start = 1'b0;
    ctl_stop  = 1'b0;
    check_eq("t3_both_busy", 32'(sts_busy), 0);
    check_eq("t3_both_out", 32'(gpio_o), 'h0);
    tick();
    check_eq("t3_both_busy2", 32'(sts_busy), 0);

    // Start in RUN is ignored
    start_pulse();
    tick();
    tick();
    start_pulse();
    check_eq("t3_norestart_step", 32'(sts_step), 1);
    check_eq("t3_norestart_out", 32'(gpio_o), 'hAA);
    check_eq("t3_norestart_busy", 32'(sts_busy), 1);
    tick();
    check_eq("t3_wrap_out", 32'(gpio_o), 'h55);
    stop_pulse();
    check_eq("t3_stop_busy", 32'(sts_busy), 0);

    // Rewrite of table[1] during step 0 shows up in the same loop
    cfg_loops = 16'd1;
    start_pulse();
    check_eq("t4_out0", 32'(gpio_o), 'h55);
    wr(4'd1, 8'hFF, 8'h0F, 16'd0);
    check_eq("t4_out1", 32'(gpio_o), 'h55);
    tick();
    check_eq("t4_out2", 32'(gpio_o), 'h55);
    tick();
    check_eq("t4_out3", 32'(gpio_o), 'h0F);
    check_eq("t4_step3", 32'(sts_step), 1);
    tick();
    check_eq("t4_irq", 32'(irq), 1);
    check_eq("t4_busy", 32'(sts_busy), 0);
    tick();

    // External trigger
    cfg_loops = 16'd0;
    trg_i = 1'b1;
`ifdef GPIO_SEQ_TRIG_EN
    tick();
    tick();
    check_eq("trg_busy_e2", 32'(sts_busy), 0);
    tick();
    check_eq("trg_busy_e3", 32'(sts_busy), 1);
    check_eq("trg_out_e3", 32'(gpio_o), 'h55);
    stop_pulse();
    repeat (5) tick();
    check_eq("trg_no_retrig", 32'(sts_busy), 0);
`else
    repeat (5) tick();
    check_eq("trg_ignored", 32'(sts_busy), 0);
    check_eq("trg_ignored_out", 32'(gpio_o), 'h0);
`endif
    trg_i = 1'b0;
    tick();

    // Asynchronous reset during a long step 1
    wr(4'd1, 8'hFF, 8'hAA, 16'd100);
    cfg_len   = 4'd1;
    cfg_loops = 16'd0;
    start_pulse();
    repeat (4) tick();
    check_eq("t5_pre_step", 32'(sts_step), 1);
    check_eq("t5_pre_out", 32'(gpio_o), 'hAA);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_rst_out", 32'(gpio_o), 'h0);
    check_eq("t5_rst_oe", 32'(gpio_e), 'h0);
    check_eq("t5_rst_busy", 32'(sts_busy), 0);
    check_eq("t5_rst_step", 32'(sts_step), 0);
    check_eq("t5_rst_irq", 32'(irq), 0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("t5_idle_after", 32'(sts_busy), 0);
    cfg_loops = 16'd1;
    start_pulse();
    check_eq("t5_zero_busy", 32'(sts_busy), 1);
    check_eq("t5_zero_out", 32'(gpio_o), 'h0);
    check_eq("t5_zero_oe", 32'(gpio_e), 'h0);
    tick();
    check_eq("t5_zero_step1", 32'(sts_step), 1);
    check_eq("t5_zero_out1", 32'(gpio_o), 'h0);
    tick();
    check_eq("t5_zero_irq", 32'(irq), 1);
    check_eq("t5_zero_done", 32'(sts_busy), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
